// File: rtl/ps2_port.sv
// PS/2 keyboard receiver with an 8-entry FIFO on a two-register CPU port.
// BASE reads the FIFO head. BASE+1 reads status {IE, OVF, FERR, PERR, count}
// and takes commands when written.
// Optional feature macro: PS2_PARITY_CHECK_EN. When it is defined, a frame with
// even parity is discarded and PERR is set.
module ps2_port #(
    parameter logic [7:0]  BASE    = 8'h60,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] port_a,
    input  logic [7:0] port_o,
    input  logic       port_w,
    output logic [7:0] port_i,
    output logic       intr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam int unsigned    WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [7:0]     BASE_STAT = BASE + 8'd1;

    logic            clk_s1, clk_s2, clk_s3;
    logic            dat_s1, dat_s2;
    logic            fall_q, dat_q;

    logic [1:0]      state;
    logic [3:0]      bit_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic [9:0]      sreg;
    logic            wd_expire;

    logic [7:0]      fifo_mem [8];
    logic [2:0]      rd_ptr, wr_ptr;
    logic [3:0]      count;
    logic            ie, ovf, ferr, perr;

    logic            frame_ok, push_req, set_ferr, set_perr;
    logic            ctl_wr, pop_req, flush_req, clr_req, ie_wr;
    logic            do_push, do_pop, set_ovf;
    logic [7:0]      head, status;
    logic            ctl_unused;

    // Synchronize both lines and register the falling edge of the PS/2 clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
            fall_q <= 1'b0;
            dat_q  <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
            fall_q <= clk_s3 & ~clk_s2;
            dat_q  <= dat_s2;
        end
    end

    assign wd_expire = (state == ST_RECV) && !fall_q && (wd_cnt == WD_LIMIT);

    // Frame receiver. It hunts for a start bit, shifts in ten bits, and then
    // spends one cycle in CHECK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            wd_cnt  <= '0;
            sreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    wd_cnt  <= '0;
                    if (fall_q && !dat_q)
                        state <= ST_RECV;
                end
                ST_RECV: begin
                    if (fall_q) begin
                        wd_cnt <= '0;
                        sreg   <= {dat_q, sreg[9:1]};
                        if (bit_cnt == 4'd9) begin
                            bit_cnt <= '0;
                            state   <= ST_CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (wd_expire) begin
                        wd_cnt  <= '0;
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_CHECK: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic parity_ok;
    assign parity_ok = ^sreg[8:0];
    assign frame_ok  = sreg[9] & parity_ok;
    assign set_perr  = (state == ST_CHECK) && sreg[9] && !parity_ok;
    assign ctl_unused = ^port_o[6:3];
`else
    assign frame_ok  = sreg[9];
    assign set_perr  = 1'b0;
    assign ctl_unused = ^{port_o[6:3], sreg[8]};
`endif

    assign push_req = (state == ST_CHECK) && frame_ok;
    assign set_ferr = ((state == ST_CHECK) && !sreg[9]) || wd_expire;

    assign ctl_wr    = port_w && (port_a == BASE_STAT);
    assign pop_req   = ctl_wr && port_o[0];
    assign flush_req = ctl_wr && port_o[1];
    assign clr_req   = ctl_wr && port_o[2];
    // A write carrying pop, flush or clear is a command and leaves IE unchanged.
    // Only a pure write (bits 2:0 all zero) loads IE from bit 7.
    assign ie_wr     = ctl_wr && (port_o[2:0] == 3'b000);

    // Flush takes priority over everything. If the FIFO is full, a pop in the
    // same cycle makes room for the incoming byte.
    assign do_pop  = pop_req && (count != 4'd0) && !flush_req;
    assign do_push = push_req && !flush_req && ((count != 4'd8) || do_pop);
    assign set_ovf = push_req && !flush_req && (count == 4'd8) && !do_pop;

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push)
            fifo_mem[wr_ptr] <= sreg[7:0];
    end

    // FIFO pointers, count, sticky flags and the interrupt register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ie     <= 1'b0;
            ovf    <= 1'b0;
            ferr   <= 1'b0;
            perr   <= 1'b0;
            intr   <= 1'b0;
        end else begin
            if (flush_req) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_pop)
                    rd_ptr <= rd_ptr + 3'd1;
                if (do_push)
                    wr_ptr <= wr_ptr + 3'd1;
                count <= count + {3'b000, do_push} - {3'b000, do_pop};
            end
            if (ie_wr)
                ie <= port_o[7];
            ovf  <= (ovf  & ~clr_req) | set_ovf;
            ferr <= (ferr & ~clr_req) | set_ferr;
            perr <= (perr & ~clr_req) | set_perr;
            intr <= ie & (count != 4'd0);
        end
    end

    assign head   = (count != 4'd0) ? fifo_mem[rd_ptr] : 8'h00;
    assign status = {ie, ovf, ferr, perr, count};

    // Zero-latency read mux.
    always_comb begin
        port_i = 8'h00;
        if (port_a == BASE)
            port_i = head;
        else if (port_a == BASE_STAT)
            port_i = status;
    end

endmodule
